// File: rtl/animation_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : animation_ctrl
//  Description : Bouncing 4x4 box animator for a 160x120 VGA pixel adapter.
//                After a go request the block draws a box, waits a number of
//                frame ticks, erases it, moves it one pixel diagonally with
//                bouncing at the screen edges, and repeats until reset.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FRAME_TICKS     : clock cycles per frame tick
//    FRAMES_PER_MOVE : frame ticks spent showing the box before it moves
//
//  Ports
//    clock      in   system clock, rising-edge
//    reset      in   asynchronous active-low reset
//    go         in   start request, only honoured while idle
//    colour_in  in   [2:0] colour for the next box drawn
//    x          out  [7:0] pixel column to the VGA adapter
//    y          out  [6:0] pixel row to the VGA adapter
//    colour     out  [2:0] pixel colour to the VGA adapter
//    writeEn    out  plot strobe, one pixel per asserted cycle
//    busy       out  high whenever the animation is running
// ============================================================================
module animation_ctrl #(
    parameter int FRAME_TICKS     = 833333,
    parameter int FRAMES_PER_MOVE = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int C_FRAME_W = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;

    localparam logic [C_TICK_W-1:0]  C_TICK_LAST  = C_TICK_W'(FRAME_TICKS - 1);
    localparam logic [C_FRAME_W-1:0] C_FRAME_LAST = C_FRAME_W'(FRAMES_PER_MOVE - 1);
    localparam logic [C_TICK_W-1:0]  C_TICK_ONE   = C_TICK_W'(1);
    localparam logic [C_FRAME_W-1:0] C_FRAME_ONE  = C_FRAME_W'(1);

    // Largest legal box origin: origin + 3 must stay on screen (159, 119).
    localparam logic [7:0] C_X_MAX = 8'd156;
    localparam logic [6:0] C_Y_MAX = 7'd116;

    localparam logic [3:0] C_PC_LAST = 4'd15;

    // Direction encodings: 1 = increasing coordinate.
    localparam logic C_DIR_RIGHT = 1'b1;
    localparam logic C_DIR_DOWN  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAW  = 3'd1,
        S_WAIT  = 3'd2,
        S_ERASE = 3'd3,
        S_MOVE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    state_t                state_q,  state_d;
    logic [7:0]            xpos_q,   xpos_d;
    logic [6:0]            ypos_q,   ypos_d;
    logic                  dx_q,     dx_d;
    logic                  dy_q,     dy_d;
    logic [2:0]            col_q,    col_d;
    logic [3:0]            pc_q,     pc_d;
    logic [C_TICK_W-1:0]   tick_q,   tick_d;
    logic [C_FRAME_W-1:0]  frame_q,  frame_d;

    // Registered VGA-side outputs
    logic [7:0]            x_q,      x_d;
    logic [6:0]            y_q,      y_d;
    logic [2:0]            colour_q, colour_d;
    logic                  we_q,     we_d;
    logic                  busy_q,   busy_d;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        col_d   = col_q;
        pc_d    = pc_q;
        tick_d  = tick_q;
        frame_d = frame_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    col_d   = colour_in;
                    pc_d    = 4'd0;
                    state_d = S_DRAW;
                end
            end

            S_DRAW: begin
                // pc wraps 15 -> 0, so it is already cleared for the next plot phase.
                pc_d = pc_q + 4'd1;
                if (pc_q == C_PC_LAST) begin
                    tick_d  = '0;
                    frame_d = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (tick_q == C_TICK_LAST) begin
                    tick_d = '0;
                    if (frame_q == C_FRAME_LAST) begin
                        frame_d = '0;
                        pc_d    = 4'd0;
                        state_d = S_ERASE;
                    end else begin
                        frame_d = frame_q + C_FRAME_ONE;
                    end
                end else begin
                    tick_d = tick_q + C_TICK_ONE;
                end
            end

            S_ERASE: begin
                pc_d = pc_q + 4'd1;
                if (pc_q == C_PC_LAST) begin
                    state_d = S_MOVE;
                end
            end

            S_MOVE: begin
                // Horizontal step; at an edge the box reflects in the same cycle.
                if (dx_q == C_DIR_RIGHT) begin
                    if (xpos_q == C_X_MAX) begin
                        dx_d   = ~C_DIR_RIGHT;
                        xpos_d = C_X_MAX - 8'd1;
                    end else begin
                        xpos_d = xpos_q + 8'd1;
                    end
                end else begin
                    if (xpos_q == 8'd0) begin
                        dx_d   = C_DIR_RIGHT;
                        xpos_d = 8'd1;
                    end else begin
                        xpos_d = xpos_q - 8'd1;
                    end
                end

                // Vertical step, same reflection rule.
                if (dy_q == C_DIR_DOWN) begin
                    if (ypos_q == C_Y_MAX) begin
                        dy_d   = ~C_DIR_DOWN;
                        ypos_d = C_Y_MAX - 7'd1;
                    end else begin
                        ypos_d = ypos_q + 7'd1;
                    end
                end else begin
                    if (ypos_q == 7'd0) begin
                        dy_d   = C_DIR_DOWN;
                        ypos_d = 7'd1;
                    end else begin
                        ypos_d = ypos_q - 7'd1;
                    end
                end

                col_d   = colour_in;
                pc_d    = 4'd0;
                state_d = S_DRAW;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode. Outputs are registered, so they are derived from the
    // next-state values: the pixel presented after an edge belongs to the
    // state entered on that edge.
    // ------------------------------------------------------------------------
    always_comb begin
        we_d     = (state_d == S_DRAW) || (state_d == S_ERASE);
        busy_d   = (state_d != S_IDLE);
        x_d      = 8'd0;
        y_d      = 7'd0;
        colour_d = 3'b000;
        if (we_d) begin
            x_d = xpos_d + {6'd0, pc_d[1:0]};
            y_d = ypos_d + {5'd0, pc_d[3:2]};
        end
        if (state_d == S_DRAW) begin
            colour_d = col_d;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            xpos_q   <= 8'd0;
            ypos_q   <= 7'd0;
            dx_q     <= C_DIR_RIGHT;
            dy_q     <= C_DIR_DOWN;
            col_q    <= 3'b000;
            pc_q     <= 4'd0;
            tick_q   <= '0;
            frame_q  <= '0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'b000;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            col_q    <= col_d;
            pc_q     <= pc_d;
            tick_q   <= tick_d;
            frame_q  <= frame_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign writeEn = we_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_animation_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_animation_ctrl
//  Description : Scoreboard bench for animation_ctrl. The stimulus process
//                predicts every plotted pixel (time, position, colour) from a
//                closed-form bouncing-box model and queues it; a monitor on
//                the falling clock edge compares every DUT cycle against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_animation_ctrl;

    localparam int FT        = 4;
    localparam int FPM       = 2;
    localparam int WAITC     = FT * FPM;
    localparam int ERASE_OFF = 16 + WAITC;
    localparam int PERIOD    = ERASE_OFF + 16 + 1;
    localparam int X_MAX     = 156;
    localparam int Y_MAX     = 116;
    localparam int N_LOOPS   = 170;
    localparam int NEVER     = 32'h7fffffff;

    typedef struct {
        int cyc;
        int px;
        int py;
        int col;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       go    = 1'b0;
    logic [2:0] colour_in = 3'b000;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn;
    logic       busy;

    int   cyc       = 0;
    int   busy_from = NEVER;
    int   n_checks  = 0;
    int   n_fail    = 0;
    exp_t q[$];
    exp_t e;

    animation_ctrl #(
        .FRAME_TICKS     (FT),
        .FRAMES_PER_MOVE (FPM)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .colour_in (colour_in),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .writeEn   (writeEn),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp_v);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    // Box origin after k moves: a triangle wave between 0 and lim.
    function automatic int bounce(input int k, input int lim);
        int p;
        p = k % (2 * lim);
        return (p <= lim) ? p : (2 * lim - p);
    endfunction

    // Queue the 16 draw pixels and 16 erase pixels of loop k starting at edge s.
    task automatic push_loop(input int s, input int k, input logic [2:0] c);
        int bx;
        int by;
        bx = bounce(k, X_MAX);
        by = bounce(k, Y_MAX);
        for (int i = 0; i < 16; i++)
            q.push_back('{s + i, bx + i % 4, by + i / 4, int'(c)});
        for (int i = 0; i < 16; i++)
            q.push_back('{s + ERASE_OFF + i, bx + i % 4, by + i / 4, 0});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge clock) begin
        check(busy === (cyc >= busy_from), "busy", int'(busy), int'(cyc >= busy_from));
        if (writeEn === 1'b1) begin
            check(x <= 8'd159, "x_range", int'(x), 159);
            check(y <= 7'd119, "y_range", int'(y), 119);
            check(q.size() > 0 && q[0].cyc == cyc, "plot_expected", cyc,
                  (q.size() > 0) ? q[0].cyc : -1);
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check(int'(x) == e.px, "plot_x", int'(x), e.px);
                check(int'(y) == e.py, "plot_y", int'(y), e.py);
                check(int'(colour) == e.col, "plot_colour", int'(colour), e.col);
            end
        end else begin
            check(writeEn === 1'b0, "writeEn_known", int'(writeEn), 0);
            check(x == 8'd0 && y == 7'd0 && colour == 3'd0, "idle_outputs",
                  int'({x, y, colour}), 0);
            check(!(q.size() > 0 && q[0].cyc == cyc), "plot_missing", 0, 1);
            if (q.size() > 0 && q[0].cyc == cyc) void'(q.pop_front());
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus and model
    // ------------------------------------------------------------------------
    initial begin
        int g;
        int g2;
        int rel;
        int k;

        #1 reset = 1'b0;
        #2;
        check(writeEn == 1'b0, "reset_writeEn", int'(writeEn), 0);
        check(busy == 1'b0, "reset_busy", int'(busy), 0);
        check(x == 8'd0, "reset_x", int'(x), 0);
        check(y == 7'd0, "reset_y", int'(y), 0);
        check(colour == 3'd0, "reset_colour", int'(colour), 0);

        repeat (3) step();
        reset = 1'b1;
        repeat ($urandom_range(2, 6)) step();

        // Start: one-cycle go pulse with colour 101.
        colour_in = 3'b101;
        go        = 1'b1;
        g         = cyc + 1;
        busy_from = g;
        push_loop(g, 0, colour_in);
        step();
        go = 1'b0;

        // Long run covering both the right and the bottom bounce.
        while (cyc < g + N_LOOPS * PERIOD + 7) begin
            rel = cyc + 1 - g;
            if (rel % PERIOD == 0) begin
                k = rel / PERIOD;
                if (k >= 2 && $urandom_range(0, 1) == 1)
                    colour_in = 3'($urandom_range(0, 7));
                push_loop(cyc + 1, k, colour_in);
            end else begin
                if (rel == 18)
                    colour_in = 3'b010;  // inside the first wait phase
                else if (rel > 2 * PERIOD && $urandom_range(0, 5) == 0)
                    colour_in = 3'($urandom_range(0, 7));
                go = 1'($urandom_range(0, 1));
            end
            step();
        end

        // Reset while pixel 7 of a draw is on the outputs.
        go = 1'b0;
        while (q.size() > 0 && q[q.size() - 1].cyc >= cyc) void'(q.pop_back());
        busy_from = NEVER;
        reset     = 1'b0;
        #1;
        check(writeEn == 1'b0, "abort_writeEn", int'(writeEn), 0);
        check(busy == 1'b0, "abort_busy", int'(busy), 0);
        check(x == 8'd0 && y == 7'd0 && colour == 3'd0, "abort_outputs",
              int'({x, y, colour}), 0);
        repeat ($urandom_range(1, 4)) step();
        reset = 1'b1;
        repeat ($urandom_range(2, 8)) step();

        // Restart with go held high for the rest of the run.
        go        = 1'b1;
        colour_in = 3'($urandom_range(0, 7));
        g2        = cyc + 1;
        busy_from = g2;
        push_loop(g2, 0, colour_in);
        step();
        while (cyc < g2 + 3 * PERIOD - 2) begin
            rel = cyc + 1 - g2;
            if (rel % PERIOD == 0)
                push_loop(cyc + 1, rel / PERIOD, colour_in);
            else if ($urandom_range(0, 4) == 0)
                colour_in = 3'($urandom_range(0, 7));
            step();
        end

        @(negedge clock);
        #1;
        check(q.size() == 0, "queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
